snake_motion_engine: RTL and testbench

- Sequences the snake body arrays that the VGA renderer consumes (x_values/y_values, 100 packed 32-bit tile coordinates).
- On each game tick it:
  - applies the latched direction,
  - checks for wall and self collision,
  - shifts the body one tile,
  - grows the snake when the new head lands on the food tile.
- Sits between the PS2/keyboard direction decoder and the VGA controller.
- All outputs are registered.

---
 rtl/snake_motion_if.sv | 29 ++
 rtl/snake_motion_engine.sv | 186 ++++++++++++++++++
 tb/tb_snake_motion_engine.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_motion_if.sv
// Handshake bundle between the game controller/bench and the snake motion engine.
// The master drives tick, restart, steering and food; the slave returns body arrays and status.
interface snake_motion_if #(
  parameter int MAX_LEN = 100
);
  logic                     step;
  logic                     restart;
  logic [1:0]               dir_in;
  logic                     dir_valid;
  logic [31:0]              food_x;
  logic [31:0]              food_y;
  logic [32*MAX_LEN-1:0]    x_values;
  logic [32*MAX_LEN-1:0]    y_values;
  logic [6:0]               length;
  logic                     busy;
  logic                     done;
  logic                     ate;
  logic                     game_over;

  modport master (
    output step, restart, dir_in, dir_valid, food_x, food_y,
    input  x_values, y_values, length, busy, done, ate, game_over
  );

  modport slave (
    input  step, restart, dir_in, dir_valid, food_x, food_y,
    output x_values, y_values, length, busy, done, ate, game_over
  );
endinterface

// File: rtl/snake_motion_engine.sv
// Snake body sequencer: per game tick applies the latched direction, checks wall and
// self collision one segment per cycle, then shifts/grows the body arrays for the renderer.
module snake_motion_engine #(
  parameter int MAX_LEN  = 100,
  parameter int GRID_W   = 8,
  parameter int GRID_H   = 8,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 4,
  parameter int INIT_Y   = 4
) (
  input  logic clk,
  input  logic reset,
  snake_motion_if.slave bus
);

  localparam logic [31:0] SENTINEL   = 32'hFFFF_FFFF;
  localparam logic [6:0]  MAX_LEN_L  = 7'(MAX_LEN);
  localparam logic [6:0]  INIT_LEN_L = 7'(INIT_LEN);
  localparam logic [31:0] X_MAX      = 32'(GRID_W - 1);
  localparam logic [31:0] Y_MAX      = 32'(GRID_H - 1);

  typedef enum logic [1:0] {IDLE, CHECK, UPDATE, DEAD} state_t;

  state_t      state_r;
  logic [31:0] xs_r [MAX_LEN];
  logic [31:0] ys_r [MAX_LEN];
  logic [6:0]  length_r;
  logic [6:0]  idx_r;
  logic [1:0]  cur_dir_r;
  logic [1:0]  pending_dir_r;
  logic [31:0] nx_r;
  logic [31:0] ny_r;
  logic        wall_r;
  logic        grow_r;
  logic        eat_r;
  logic        busy_r;
  logic        done_r;
  logic        ate_r;
  logic        game_over_r;

  logic [31:0] nx_s;
  logic [31:0] ny_s;
  logic        wall_s;
  logic        eat_s;
  logic        hit_s;
  logic        no_cmp_s;
  logic [6:0]  last_idx_s;

  // Candidate head for the direction that a tick would apply, plus its wall/food status.
  always_comb begin
    nx_s   = xs_r[0];
    ny_s   = ys_r[0];
    wall_s = 1'b0;
    case (pending_dir_r)
      2'd0: begin
        ny_s   = ys_r[0] - 32'd1;
        wall_s = (ys_r[0] == 32'd0);
      end
      2'd1: begin
        nx_s   = xs_r[0] + 32'd1;
        wall_s = (xs_r[0] == X_MAX);
      end
      2'd2: begin
        ny_s   = ys_r[0] + 32'd1;
        wall_s = (ys_r[0] == Y_MAX);
      end
      2'd3: begin
        nx_s   = xs_r[0] - 32'd1;
        wall_s = (xs_r[0] == 32'd0);
      end
      default: begin
        nx_s   = xs_r[0];
        ny_s   = ys_r[0];
        wall_s = 1'b0;
      end
    endcase
    eat_s = (nx_s == bus.food_x) && (ny_s == bus.food_y);
  end

  // Self-collision compare; the tail slot is skipped unless growing because it vacates.
  always_comb begin
    hit_s      = (nx_r == xs_r[idx_r]) && (ny_r == ys_r[idx_r]);
    no_cmp_s   = (length_r == 7'd1) && !grow_r;
    if (grow_r) begin
      last_idx_s = length_r - 7'd1;
    end else begin
      last_idx_s = length_r - 7'd2;
    end
  end

  // Main sequencer: direction latch, tick FSM and body storage.
  always_ff @(posedge clk) begin
    if (!reset || bus.restart) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        xs_r[i] <= (i < INIT_LEN) ? 32'(INIT_X - i) : SENTINEL;
        ys_r[i] <= (i < INIT_LEN) ? 32'(INIT_Y) : SENTINEL;
      end
      state_r       <= IDLE;
      length_r      <= INIT_LEN_L;
      idx_r         <= 7'd0;
      cur_dir_r     <= 2'd1;
      pending_dir_r <= 2'd1;
      nx_r          <= 32'd0;
      ny_r          <= 32'd0;
      wall_r        <= 1'b0;
      grow_r        <= 1'b0;
      eat_r         <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      ate_r         <= 1'b0;
      game_over_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      ate_r  <= 1'b0;

      if ((state_r != DEAD) && bus.dir_valid &&
          !((length_r > 7'd1) && (bus.dir_in == (cur_dir_r ^ 2'd2)))) begin
        pending_dir_r <= bus.dir_in;
      end

      case (state_r)
        IDLE: begin
          if (bus.step) begin
            cur_dir_r <= pending_dir_r;
            nx_r      <= nx_s;
            ny_r      <= ny_s;
            wall_r    <= wall_s;
            eat_r     <= eat_s;
            grow_r    <= eat_s && (length_r < MAX_LEN_L);
            idx_r     <= 7'd0;
            busy_r    <= 1'b1;
            state_r   <= CHECK;
          end
        end
        CHECK: begin
          if (wall_r || (!no_cmp_s && hit_s)) begin
            game_over_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= DEAD;
          end else if (no_cmp_s || (idx_r == last_idx_s)) begin
            state_r <= UPDATE;
          end else begin
            idx_r <= idx_r + 7'd1;
          end
        end
        UPDATE: begin
          for (int i = 1; i < MAX_LEN; i++) begin
            xs_r[i] <= xs_r[i-1];
            ys_r[i] <= ys_r[i-1];
          end
          xs_r[0] <= nx_r;
          ys_r[0] <= ny_r;
          if (grow_r) begin
            length_r <= length_r + 7'd1;
          end else if (length_r < MAX_LEN_L) begin
            xs_r[length_r] <= SENTINEL;
            ys_r[length_r] <= SENTINEL;
          end
          done_r  <= 1'b1;
          ate_r   <= eat_r;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        DEAD: begin
          game_over_r <= 1'b1;
          busy_r      <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
    assign bus.x_values[32*g +: 32] = xs_r[g];
    assign bus.y_values[32*g +: 32] = ys_r[g];
  end

  assign bus.length    = length_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.ate       = ate_r;
  assign bus.game_over = game_over_r;

endmodule

// File: tb/tb_snake_motion_engine.sv
// Scoreboard bench: a queue-based snake model predicts each tick's outcome; a monitor
// process pops predictions when the engine reports done or raises game_over.
module tb_snake_motion_engine;
  localparam int ML = 100;
  localparam int GW = 8;
  localparam int GH = 8;
  localparam int IL = 3;
  localparam int IX = 4;
  localparam int IY = 4;

  typedef struct {
    bit                  dead;
    bit                  ate;
    int                  len;
    logic [32*ML-1:0]    xv;
    logic [32*ML-1:0]    yv;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  snake_motion_if #(.MAX_LEN(ML)) bus ();

  snake_motion_engine #(
    .MAX_LEN(ML), .GRID_W(GW), .GRID_H(GH),
    .INIT_LEN(IL), .INIT_X(IX), .INIT_Y(IY)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int unsigned mx[$];
  int unsigned my[$];
  int          m_cur;
  int          m_pend;
  bit          m_dead;
  exp_t        sb[$];
  exp_t        mon_e;
  bit          go_prev = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_arr(input string name, input logic [32*ML-1:0] act, input logic [32*ML-1:0] exp);
    int bad;
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      bad = 0;
      for (int i = ML - 1; i >= 0; i--) begin
        if (act[32*i +: 32] !== exp[32*i +: 32]) bad = i;
      end
      $display("FAIL %s: slot %0d got %h expected %h", name, bad, act[32*bad +: 32], exp[32*bad +: 32]);
    end
  endtask

  function automatic logic [32*ML-1:0] pack_q(input int unsigned q[$]);
    logic [32*ML-1:0] v;
    v = {ML{32'hFFFF_FFFF}};
    for (int i = 0; i < q.size(); i++) v[32*i +: 32] = q[i];
    return v;
  endfunction

  task automatic model_reset();
    mx.delete();
    my.delete();
    for (int i = 0; i < IL; i++) begin
      mx.push_back(IX - i);
      my.push_back(IY);
    end
    m_cur  = 1;
    m_pend = 1;
    m_dead = 1'b0;
  endtask

  task automatic model_next(input int d, output int unsigned nx, output int unsigned ny, output bit wall);
    nx = mx[0];
    ny = my[0];
    wall = 1'b0;
    case (d)
      0: begin wall = (my[0] == 0);      ny = my[0] - 1; end
      1: begin wall = (mx[0] == GW - 1); nx = mx[0] + 1; end
      2: begin wall = (my[0] == GH - 1); ny = my[0] + 1; end
      default: begin wall = (mx[0] == 0); nx = mx[0] - 1; end
    endcase
  endtask

  task automatic check_idle_state(input string tag);
    chk({tag, "_length"}, 64'(bus.length), 64'(mx.size()));
    chk_arr({tag, "_x"}, bus.x_values, pack_q(mx));
    chk_arr({tag, "_y"}, bus.y_values, pack_q(my));
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_game_over"}, 64'(bus.game_over), 64'(m_dead));
  endtask

  task automatic do_restart();
    bus.restart = 1'b1;
    @(posedge clk);
    #1 bus.restart = 1'b0;
    model_reset();
    @(negedge clk);
    check_idle_state("restart");
  endtask

  task automatic req_dir(input int d);
    bus.dir_in    = 2'(d);
    bus.dir_valid = 1'b1;
    @(posedge clk);
    #1 bus.dir_valid = 1'b0;
    if (!m_dead && !(mx.size() > 1 && d == (m_cur ^ 2))) m_pend = d;
  endtask

  task automatic set_food(input int unsigned fx, input int unsigned fy);
    bus.food_x = fx;
    bus.food_y = fy;
  endtask

  task automatic do_step(input bit poke_busy);
    exp_t e;
    int unsigned nx, ny;
    bit wall, eat, grow, dead;
    int ncmp;
    if (m_dead) begin
      bus.step = 1'b1;
      @(posedge clk);
      #1 bus.step = 1'b0;
      repeat (8) @(negedge clk);
      check_idle_state("dead_step_ignored");
      return;
    end
    m_cur = m_pend;
    model_next(m_cur, nx, ny, wall);
    eat  = (nx == bus.food_x) && (ny == bus.food_y);
    grow = eat && (mx.size() < ML);
    dead = wall;
    ncmp = grow ? mx.size() : mx.size() - 1;
    if (!wall) begin
      for (int i = 0; i < ncmp; i++) begin
        if (mx[i] == nx && my[i] == ny) dead = 1'b1;
      end
    end
    e.dead = dead;
    e.ate  = 1'b0;
    if (!dead) begin
      mx.push_front(nx);
      my.push_front(ny);
      if (!grow) begin
        void'(mx.pop_back());
        void'(my.pop_back());
      end
      e.ate = eat;
    end else begin
      m_dead = 1'b1;
    end
    e.len = mx.size();
    e.xv  = pack_q(mx);
    e.yv  = pack_q(my);
    sb.push_back(e);

    bus.step = 1'b1;
    @(posedge clk);
    #1 bus.step = 1'b0;
    chk("busy_after_step", 64'(bus.busy), 64'd1);
    if (poke_busy) begin
      bus.step = 1'b1;
      @(posedge clk);
      #1 bus.step = 1'b0;
    end
    for (int c = 0; c <= 400; c++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
      if (c == 400) begin
        chk("step_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
      end
    end
    if (poke_busy) repeat (6) @(negedge clk);
  endtask

  // Monitor: consumes one prediction per done pulse or game_over rise.
  always @(negedge clk) begin
    if (bus.ate && !bus.done) chk("ate_without_done", 64'(bus.ate), 64'd0);
    if (bus.done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 64'(bus.done), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_expected_death", 64'(mon_e.dead), 64'd0);
        chk("done_ate", 64'(bus.ate), 64'(mon_e.ate));
        chk("done_length", 64'(bus.length), 64'(mon_e.len));
        chk("done_busy", 64'(bus.busy), 64'd0);
        chk("done_game_over", 64'(bus.game_over), 64'd0);
        chk_arr("done_x", bus.x_values, mon_e.xv);
        chk_arr("done_y", bus.y_values, mon_e.yv);
      end
    end
    if (bus.game_over && !go_prev) begin
      if (sb.size() == 0) begin
        chk("spurious_game_over", 64'(bus.game_over), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("death_expected", 64'(mon_e.dead), 64'd1);
        chk("death_busy", 64'(bus.busy), 64'd0);
        chk("death_length", 64'(bus.length), 64'(mon_e.len));
        chk_arr("death_x_frozen", bus.x_values, mon_e.xv);
        chk_arr("death_y_frozen", bus.y_values, mon_e.yv);
      end
    end
    go_prev <= bus.game_over;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b0;
    bus.step      = 1'b0;
    bus.restart   = 1'b0;
    bus.dir_in    = 2'd0;
    bus.dir_valid = 1'b0;
    set_food(7, 7);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    @(negedge clk);
    check_idle_state("reset");

    // Plain move, no food.
    do_step(1'b0);
    // Eat directly ahead from reset: grows to 4.
    do_restart();
    set_food(5, 4);
    do_step(1'b0);
    // Reversal rejected, then last accepted request wins.
    do_restart();
    set_food(7, 7);
    req_dir(3);
    do_step(1'b0);
    req_dir(0);
    req_dir(1);
    do_step(1'b0);
    // Run into the right wall, then steps are ignored until restart.
    do_restart();
    repeat (4) do_step(1'b0);
    do_step(1'b0);
    do_restart();
    // Grow to five, then turn back into the body.
    set_food(5, 4);
    do_step(1'b0);
    set_food(6, 4);
    do_step(1'b0);
    set_food(0, 0);
    req_dir(2);
    do_step(1'b0);
    req_dir(3);
    do_step(1'b0);
    req_dir(0);
    do_step(1'b0);
    // Length-4 loop into the vacating tail, with a tick poked while busy.
    do_restart();
    set_food(5, 4);
    do_step(1'b0);
    set_food(0, 0);
    req_dir(2);
    do_step(1'b0);
    req_dir(3);
    do_step(1'b0);
    req_dir(0);
    do_step(1'b1);
    chk("tail_chase_alive", 64'(bus.game_over), 64'd0);

    // Randomized play.
    do_restart();
    for (int it = 0; it < 300; it++) begin
      int unsigned fx, fy;
      bit w;
      if (m_dead) do_restart();
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) req_dir(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) begin
        model_next(m_pend, fx, fy, w);
        set_food(fx, fy);
      end else begin
        set_food($urandom_range(0, GW - 1), $urandom_range(0, GH - 1));
      end
      do_step($urandom_range(0, 7) == 0);
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
